// File: rtl/dmem_arbiter_if.sv
// Request/response bus between two requesters, the arbiter and the data memory.
interface dmem_arbiter_if;
    logic        req0;
    logic        we0;
    logic [63:0] addr0;
    logic [63:0] wdata0;
    logic        ack0;
    logic [63:0] rdata0;
    logic        err0;
    logic        stall0;

    logic        req1;
    logic        we1;
    logic [63:0] addr1;
    logic [63:0] wdata1;
    logic        ack1;
    logic [63:0] rdata1;
    logic        err1;

    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_rdata;

    // Environment side: requesters plus the memory array.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, err0, stall0,
        input  ack1, rdata1, err1,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, err0, stall0,
        output ack1, rdata1, err1,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// Port 0 (pipeline MEM stage) wins by default; port 1 (loader) is forced
// after STARVE_LIMIT consecutive port-0 grants while it waits.
module dmem_arbiter #(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic          win;
    logic          lat_we;
    logic [63:0]   lat_addr;
    logic [63:0]   lat_wdata;
    logic [SW-1:0] starve_cnt;
    logic [2:0]    wait_cnt;
    logic          grant1;
    logic          oor;

    logic          ack0_q;
    logic          ack1_q;
    logic          err0_q;
    logic          err1_q;
    logic [63:0]   rdata0_q;
    logic [63:0]   rdata1_q;

    assign oor = |lat_addr[63:ADDR_BITS];

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.err0   = err0_q;
    assign bus.err1   = err1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.stall0 = bus.req0 & ~ack0_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, arbitration decision and memory strobes.
    always_comb begin
        state_nx      = state;
        grant1        = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        case (state)
            S_IDLE: begin
                grant1 = bus.req1 & (~bus.req0 | (starve_cnt == SW'(STARVE_LIMIT)));
                if (bus.req0 | bus.req1) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.mem_addr  = 64'(lat_addr[ADDR_BITS-1:0]);
                bus.mem_wdata = lat_wdata;
                if (!oor) begin
                    bus.mem_write = lat_we;
                    bus.mem_read  = ~lat_we;
                end
                state_nx = (!oor && !lat_we) ? S_WAIT : S_ACK;
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nx = S_ACK;
                end
            end
            S_ACK: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request latching, starvation counter, read capture and ack/err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            // win only changes in IDLE, so it is stable whenever ACK is entered.
            ack0_q <= (state_nx == S_ACK) && !win;
            ack1_q <= (state_nx == S_ACK) && win;
            err0_q <= (state_nx == S_ACK) && !win && oor;
            err1_q <= (state_nx == S_ACK) && win && oor;
            case (state)
                S_IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        win       <= grant1;
                        lat_we    <= grant1 ? bus.we1 : bus.we0;
                        lat_addr  <= grant1 ? bus.addr1 : bus.addr0;
                        lat_wdata <= grant1 ? bus.wdata1 : bus.wdata0;
                        if (grant1) begin
                            starve_cnt <= '0;
                        end else if (bus.req1 && (starve_cnt != SW'(STARVE_LIMIT))) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= 3'(RD_LATENCY - 1);
                    if (oor && !lat_we) begin
                        if (win) begin
                            rdata1_q <= '0;
                        end else begin
                            rdata0_q <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        if (win) begin
                            rdata1_q <= bus.mem_rdata;
                        end else begin
                            rdata0_q <= bus.mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed latency/arbitration/range cases, randomized
// two-port traffic, and a reset-during-read case on an RD_LATENCY=3 instance.
module tb_dmem_arbiter;
    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst3 = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus3();

    dmem_arbiter #(.ADDR_BITS(8), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    dmem_arbiter #(.ADDR_BITS(8), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave)
    );

    typedef struct packed {
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sbq0[$];
    exp_t sbq1[$];
    int   grant_log[$];

    logic [63:0] sb_mem [256];
    logic [63:0] last_rd [2];
    int exp_rd = 0;
    int exp_wr = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [63:0] last_strobe_addr = '0;
    int ack3_cnt = 0;

    // Memory array models (synchronous read, latency 1 and 3).
    logic [63:0] ram [256];
    logic [63:0] rpipe;
    logic [63:0] ram3 [256];
    logic [63:0] p3 [3];

    assign bus.mem_rdata  = rpipe;
    assign bus3.mem_rdata = p3[2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 64'(i);
            rpipe <= '0;
        end else begin
            if (bus.mem_write) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            rpipe <= bus.mem_read ? ram[bus.mem_addr[7:0]] : 64'hA5A5_5A5A_0F0F_F0F0;
        end
    end

    always @(posedge clk) begin
        if (rst3) begin
            for (int i = 0; i < 256; i++) ram3[i] <= 64'(i);
            for (int i = 0; i < 3; i++) p3[i] <= '0;
        end else begin
            if (bus3.mem_write) ram3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
            p3[0] <= bus3.mem_read ? ram3[bus3.mem_addr[7:0]] : 64'h5A5A_A5A5_F0F0_0F0F;
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Response monitor for the main instance.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (bus.ack0) begin
                grant_log.push_back(0);
                if (sbq0.size() == 0) fail("ack0 with nothing outstanding");
                else begin
                    e = sbq0.pop_front();
                    chk("rdata0", bus.rdata0, e.rdata);
                    chk("err0", 64'(bus.err0), 64'(e.err));
                end
            end
            if (bus.ack1) begin
                grant_log.push_back(1);
                if (sbq1.size() == 0) fail("ack1 with nothing outstanding");
                else begin
                    e = sbq1.pop_front();
                    chk("rdata1", bus.rdata1, e.rdata);
                    chk("err1", 64'(bus.err1), 64'(e.err));
                end
            end
            if (bus.mem_read || bus.mem_write) begin
                chk("strobe_excl", 64'(bus.mem_read & bus.mem_write), 64'd0);
                chk("mem_addr_hi", bus.mem_addr >> 8, 64'd0);
                if (bus.mem_read) rd_cnt++;
                if (bus.mem_write) wr_cnt++;
                last_strobe_addr = bus.mem_addr;
            end
            if (bus.req0 || bus.stall0)
                chk("stall0", 64'(bus.stall0), 64'(bus.req0 & ~bus.ack0));
        end
    end

    always @(negedge clk) begin
        if (bus3.ack0) ack3_cnt++;
    end

    task automatic idle(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    // Issue one request on port p, record its expected outcome, hold until ack.
    task automatic do_req(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, output int lat);
        exp_t e;
        logic oor;
        logic ok;
        logic [7:0] a;
        int n;
        oor = |addr[63:8];
        a = addr[7:0];
        if (oor) begin
            if (!we) last_rd[p] = '0;
        end else if (we) begin
            sb_mem[a] = wd;
            exp_wr++;
        end else begin
            last_rd[p] = sb_mem[a];
            exp_rd++;
        end
        e.err = oor;
        e.rdata = last_rd[p];
        if (p == 0) begin
            sbq0.push_back(e);
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; bus.req0 = 1'b1;
        end else begin
            sbq1.push_back(e);
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.req1 = 1'b1;
        end
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            ok = (p == 0) ? bus.ack0 : bus.ack1;
        end
        if (!ok) fail($sformatf("timeout waiting for ack%0d", p));
        @(posedge clk);
        #1;
        if (p == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
        lat = n;
    endtask

    task automatic rand_req(input int p);
        logic we;
        logic [63:0] addr;
        logic [63:0] wd;
        int lat;
        idle(int'($urandom_range(0, 3)));
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0)
            addr = {$urandom, $urandom} | (64'h1 << $urandom_range(8, 63));
        else
            addr = 64'(p * 128 + int'($urandom_range(0, 15)));
        wd = {$urandom, $urandom};
        do_req(p, we, addr, wd, lat);
    endtask

    task automatic wait_ack3(output int n);
        logic ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            ok = bus3.ack0;
        end
        if (!ok) fail("timeout waiting for ack0 on latency-3 instance");
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat_a;
        int lat_b;
        int r0;
        int a3;
        int exp_order [10];
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        for (int i = 0; i < 256; i++) sb_mem[i] = 64'(i);
        last_rd[0] = '0;
        last_rd[1] = '0;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        bus3.req0 = 0; bus3.we0 = 0; bus3.addr0 = '0; bus3.wdata0 = '0;
        bus3.req1 = 0; bus3.we1 = 0; bus3.addr1 = '0; bus3.wdata1 = '0;

        #1;
        rst = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({bus.ack0, bus.ack1, bus.err0, bus.err1,
                               bus.mem_read, bus.mem_write, bus.stall0}), 64'd0);
        chk("reset_rdata0", bus.rdata0, 64'd0);
        chk("reset_rdata1", bus.rdata1, 64'd0);
        chk("reset_mem_addr", bus.mem_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rst3 = 1'b0;
        @(posedge clk);
        #1;

        // Port-0 load of preloaded word 5.
        r0 = rd_cnt;
        do_req(0, 1'b0, 64'd5, 64'd0, lat);
        chk("p0_load_latency", 64'(lat), 64'd3);
        chk("p0_load_read_strobes", 64'(rd_cnt - r0), 64'd1);
        chk("p0_load_mem_addr", last_strobe_addr, 64'd5);

        // Port-1 store, then port-0 load of the same word.
        do_req(1, 1'b1, 64'd12, 64'hDEAD_BEEF, lat);
        chk("p1_store_latency", 64'(lat), 64'd2);
        do_req(0, 1'b0, 64'd12, 64'd0, lat);
        chk("p0_load12_latency", 64'(lat), 64'd3);

        // Out-of-range load and store.
        r0 = rd_cnt + wr_cnt;
        do_req(0, 1'b0, 64'h100, 64'd0, lat);
        chk("oor_load_latency", 64'(lat), 64'd2);
        do_req(0, 1'b1, 64'h100, 64'h1234, lat);
        chk("oor_store_latency", 64'(lat), 64'd2);
        chk("oor_no_strobe", 64'(rd_cnt + wr_cnt - r0), 64'd0);

        // Both ports requesting continuously.
        idle(1);
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) do_req(0, 1'b0, 64'(20 + i), 64'd0, lat_a);
            end
            begin
                for (int i = 0; i < 2; i++) do_req(1, 1'b0, 64'(140 + i), 64'd0, lat_b);
            end
        join
        chk("grant_count", 64'(grant_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("grant_order[%0d]", i), 64'(grant_log[i]), 64'(exp_order[i]));

        // Randomized traffic on both ports.
        fork
            begin
                for (int i = 0; i < 40; i++) rand_req(0);
            end
            begin
                for (int i = 0; i < 40; i++) rand_req(1);
            end
        join
        chk("sb0_drained", 64'(sbq0.size()), 64'd0);
        chk("sb1_drained", 64'(sbq1.size()), 64'd0);
        chk("read_strobe_total", 64'(rd_cnt), 64'(exp_rd));
        chk("write_strobe_total", 64'(wr_cnt), 64'(exp_wr));

        // RD_LATENCY=3 instance: normal load, reset during WAIT, fresh load.
        @(posedge clk);
        #1;
        bus3.we0 = 1'b0; bus3.addr0 = 64'd9; bus3.req0 = 1'b1;
        wait_ack3(lat);
        chk("l3_load_latency", 64'(lat), 64'd5);
        chk("l3_load_rdata", bus3.rdata0, 64'd9);
        @(posedge clk);
        #1;
        bus3.req0 = 1'b0;
        idle(1);
        bus3.addr0 = 64'd7; bus3.req0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst3 = 1'b1;
        bus3.req0 = 1'b0;
        #1;
        chk("l3_rst_rdata0", bus3.rdata0, 64'd0);
        chk("l3_rst_ctrl", 64'({bus3.ack0, bus3.err0, bus3.mem_read,
                                bus3.mem_write, bus3.stall0}), 64'd0);
        chk("l3_rst_mem_addr", bus3.mem_addr, 64'd0);
        a3 = ack3_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("l3_no_ack_after_reset", 64'(ack3_cnt - a3), 64'd0);
        bus3.addr0 = 64'd7; bus3.req0 = 1'b1;
        wait_ack3(lat);
        chk("l3_fresh_latency", 64'(lat), 64'd5);
        chk("l3_fresh_rdata", bus3.rdata0, 64'd7);
        @(posedge clk);
        #1;
        bus3.req0 = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
